// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared axis timing types and mode presets.
// Used by vga_axis_counter and vga_timing_gen.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
  } mode_t;

  localparam mode_t VGA_640x480_60 = '{
    h: '{640, 16, 96, 48},
    v: '{480, 10, 2, 33}
  };

  localparam mode_t VGA_800x600_60 = '{
    h: '{800, 40, 128, 88},
    v: '{600, 1, 4, 23}
  };

  function automatic int unsigned axis_total(axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: video timing bundle from generator to consumers.
// master drives the counts, syncs and strobes; slave observes them.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = 12
);
  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;
  logic             hSync;
  logic             vSync;
  logic             videoActive;
  logic             EndOfLine;
  logic             EndOfFrame;
  logic             genTick;

  modport master (
    output hCount, vCount, hSync, vSync,
    output videoActive, EndOfLine, EndOfFrame, genTick
  );

  modport slave (
    input hCount, vCount, hSync, vSync,
    input videoActive, EndOfLine, EndOfFrame, genTick
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one wrapping timing axis with enable, wrap strobe
// and registered sync/active decode aligned with the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sync_o,
  output logic             active_o,
  output logic             wrap_o
);

  localparam int unsigned TOTAL =
    axis_total(axis_t'{ACTIVE, FP, SYNC, BP});
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] A_HI = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] S_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] S_HI = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_q, sync_d;
  logic             act_q, act_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);
  assign wrap_o  = en_i & at_last;

  // Next count and its decode, so outputs line up with the count.
  always_comb begin
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
    sync_d = ((cnt_d >= S_LO) && (cnt_d < S_HI)) ? POL : ~POL;
    act_d  = (cnt_d < A_HI);
  end

  // Reset state equals the decode of count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sync_q <= ~POL;
      act_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
      act_q  <= act_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign sync_o   = sync_q;
  assign active_o = act_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing from one pixel clock.
// Define VGA_TIMING_GEN_TICK_EN for the frame-divided genTick pulse.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VGA_640x480_60.h.active,
  parameter int unsigned H_FP      = VGA_640x480_60.h.fp,
  parameter int unsigned H_SYNC    = VGA_640x480_60.h.sync,
  parameter int unsigned H_BP      = VGA_640x480_60.h.bp,
  parameter int unsigned V_ACTIVE  = VGA_640x480_60.v.active,
  parameter int unsigned V_FP      = VGA_640x480_60.v.fp,
  parameter int unsigned V_SYNC    = VGA_640x480_60.v.sync,
  parameter int unsigned V_BP      = VGA_640x480_60.v.bp,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned FRAME_DIV = 4
) (
  input  logic              pixelClk,
  input  logic              rst_n,
  input  logic              en,
  vga_timing_gen_if.master  vid
);

  localparam int unsigned H_TOTAL =
    axis_total(axis_t'{H_ACTIVE, H_FP, H_SYNC, H_BP});
  localparam int unsigned V_TOTAL =
    axis_total(axis_t'{V_ACTIVE, V_FP, V_SYNC, V_BP});
  localparam int unsigned MAX_T =
    (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam longint unsigned CAP = 64'd1 << CNT_W;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      CNT_W == 0 || FRAME_DIV == 0) begin : g_bad_par
    $fatal(1, "vga_timing_gen: width parameter below 1");
  end

  if (CAP < 64'(MAX_T)) begin : g_bad_cnt
    $fatal(1, "vga_timing_gen: CNT_W too small for totals");
  end

  logic h_act, v_act, h_wrap, v_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HSYNC_POL), .CNT_W(CNT_W)
  ) u_h (
    .clk(pixelClk), .rst_n(rst_n), .en_i(en),
    .cnt_o(vid.hCount), .sync_o(vid.hSync),
    .active_o(h_act), .wrap_o(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VSYNC_POL), .CNT_W(CNT_W)
  ) u_v (
    .clk(pixelClk), .rst_n(rst_n), .en_i(h_wrap),
    .cnt_o(vid.vCount), .sync_o(vid.vSync),
    .active_o(v_act), .wrap_o(v_wrap)
  );

  assign vid.videoActive = h_act & v_act;
  assign vid.EndOfLine   = h_wrap;
  assign vid.EndOfFrame  = v_wrap;

`ifdef VGA_TIMING_GEN_TICK_EN
  localparam int unsigned FW =
    (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FRAME_DIV - 1);

  logic [FW-1:0] frm_q, frm_d;

  // Count frames modulo FRAME_DIV.
  always_comb begin
    frm_d = frm_q;
    if (v_wrap) begin
      frm_d = (frm_q == F_LAST) ? '0 : frm_q + FW'(1);
    end
  end

  // Frame counter register.
  always_ff @(posedge pixelClk or negedge rst_n) begin
    if (!rst_n) frm_q <= '0;
    else        frm_q <= frm_d;
  end

  assign vid.genTick = v_wrap & (frm_q == F_LAST);
`else
  assign vid.genTick = 1'b0;
`endif

endmodule
